layer_sequencer: RTL and testbench



---
 rtl/layer_sequencer_pkg.sv | 26 ++
 rtl/layer_sequencer_if.sv | 36 +++
 rtl/layer_cfg_regfile.sv | 36 +++
 rtl/layer_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and the
// per-layer configuration descriptor carried from host to core scheduler.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        LOAD   = 3'd2,
        LAUNCH = 3'd3,
        RUN    = 3'd4,
        GAP    = 3'd5,
        FINISH = 3'd6
    } seq_state_e;

    // One descriptor per network layer.
    typedef struct packed {
        logic [7:0]  filter_size;
        logic [15:0] channels;
        logic [15:0] ofmap_size;
        logic [7:0]  stride;
        logic [15:0] pass_count;
    } layer_cfg_t;

    localparam int unsigned LAYER_CFG_W = $bits(layer_cfg_t);

endpackage : layer_sequencer_pkg

// File: rtl/layer_sequencer_if.sv
// Descriptor handshake and layer start/done strobes between the layer
// sequencer (master) and the core scheduler (slave).
//   layer_cfg        descriptor presented to the scheduler
//   layer_cfg_valid  descriptor valid
//   layer_cfg_ready  scheduler accepts the descriptor
//   layer_start      one-cycle layer launch pulse
//   layer_done       one-cycle layer completion pulse from the core
interface layer_sequencer_if
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned CFG_W = LAYER_CFG_W
);

    logic [CFG_W-1:0] layer_cfg;
    logic             layer_cfg_valid;
    logic             layer_cfg_ready;
    logic             layer_start;
    logic             layer_done;

    modport master (
        output layer_cfg,
        output layer_cfg_valid,
        output layer_start,
        input  layer_cfg_ready,
        input  layer_done
    );

    modport slave (
        input  layer_cfg,
        input  layer_cfg_valid,
        input  layer_start,
        output layer_cfg_ready,
        output layer_done
    );

endinterface : layer_sequencer_if

// File: rtl/layer_cfg_regfile.sv
// Descriptor storage: NUM_LAYERS x CFG_W, one write port, one
// combinational read port. All slots clear on reset.
//   clk, rst_n        clock, async active-low reset
//   wr_en/idx/data    host write port
//   rd_idx            read slot select
//   rd_data_c         combinational read data
module layer_cfg_regfile #(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned CFG_W      = 64,
    localparam int unsigned IDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CFG_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CFG_W-1:0] rd_data_c
);

    logic [CFG_W-1:0] mem_q [NUM_LAYERS];

    // Slot writes; indices beyond the slot count are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_LAYERS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_idx) < NUM_LAYERS)) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_idx];

endmodule : layer_cfg_regfile

// File: rtl/layer_sequencer.sv
// Walks the enabled network layers in ascending order: hands each
// descriptor to the scheduler, launches the layer, waits for its done
// (guarded by a watchdog) and inserts a fixed idle gap.
//   core_clk, core_reset_n   clock, async active-low reset
//   cfg_wr_en/idx/data       host descriptor writes (any state)
//   layer_en                 enable mask, sampled at start
//   tmo_limit                watchdog limit, 0 disables
//   start, abort             single-cycle host requests
//   core                     descriptor handshake / start / done to scheduler
//   cur_layer                index of the active layer
//   busy                     sequence in progress (through FINISH)
//   seq_done                 one-cycle pulse at sequence completion
//   error                    sticky watchdog/abort flag, cleared by start
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned CFG_W      = LAYER_CFG_W,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TMO_W      = 24,
    localparam int unsigned IDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  core_clk,
    input  logic                  core_reset_n,
    input  logic                  cfg_wr_en,
    input  logic [IDX_W-1:0]      cfg_wr_idx,
    input  logic [CFG_W-1:0]      cfg_wr_data,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [TMO_W-1:0]      tmo_limit,
    input  logic                  start,
    input  logic                  abort,
    layer_sequencer_if.master     core,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  error
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_LAYERS-1:0] en_q, en_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [TMO_W-1:0]      wdog_q, wdog_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  seq_done_q, seq_done_d;
    logic                  error_q, error_d;

    logic [CFG_W-1:0]      rd_data_c;
    logic [CFG_W-1:0]      slot_cfg_c;
    logic [TMO_W-1:0]      wdog_inc_c;

    layer_cfg_regfile #(
        .NUM_LAYERS (NUM_LAYERS),
        .CFG_W      (CFG_W)
    ) u_regfile (
        .clk       (core_clk),
        .rst_n     (core_reset_n),
        .wr_en     (cfg_wr_en),
        .wr_idx    (cfg_wr_idx),
        .wr_data   (cfg_wr_data),
        .rd_idx    (idx_q),
        .rd_data_c (rd_data_c)
    );

    // Forward a same-cycle write to the active slot so a late host update
    // still reaches the presented descriptor before the handshake.
    assign slot_cfg_c = (cfg_wr_en && (cfg_wr_idx == idx_q)) ? cfg_wr_data : rd_data_c;

    // Saturating watchdog increment.
    assign wdog_inc_c = (wdog_q == '1) ? wdog_q : wdog_q + TMO_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        gap_d   = gap_q;
        wdog_d  = wdog_q;
        error_d = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    en_d    = layer_en;
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (en_q[idx_q]) begin
                    state_d = LOAD;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            LOAD: begin
                if (core.layer_cfg_ready) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wdog_d = wdog_inc_c;
                // A done in the expiry cycle takes precedence over the watchdog.
                if (core.layer_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end else if ((tmo_limit != '0) && (wdog_inc_c >= tmo_limit)) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SCAN;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything; in FINISH the sequence is already
        // ending, so only the error flag is recorded.
        if (abort && (state_q != IDLE)) begin
            error_d = 1'b1;
            if (state_q != FINISH) begin
                state_d = FINISH;
            end
        end

        cfg_valid_d = (state_d == LOAD);
        start_d     = (state_d == LAUNCH);
        busy_d      = (state_d != IDLE);
        seq_done_d  = (state_d == FINISH) && (state_q != FINISH);
        // Descriptor tracks the slot while presented; frozen after the handshake.
        cfg_d       = (state_d == LOAD) ? slot_cfg_c : cfg_q;
    end

    // State and registered outputs.
    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            en_q        <= '0;
            gap_q       <= '0;
            wdog_q      <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            gap_q       <= gap_d;
            wdog_q      <= wdog_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            error_q     <= error_d;
        end
    end

    assign core.layer_cfg       = cfg_q;
    assign core.layer_cfg_valid = cfg_valid_q;
    assign core.layer_start     = start_q;
    assign cur_layer            = idx_q;
    assign busy                 = busy_q;
    assign seq_done             = seq_done_q;
    assign error                = error_q;

endmodule : layer_sequencer

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a hand-computed expectation at
// every step.
module tb_layer_sequencer;

    localparam int unsigned NL    = 8;
    localparam int unsigned CW    = 64;
    localparam int unsigned TW    = 24;
    localparam int unsigned IW    = 3;

    logic          core_clk;
    logic          core_reset_n;
    logic          cfg_wr_en;
    logic [IW-1:0] cfg_wr_idx;
    logic [CW-1:0] cfg_wr_data;
    logic [NL-1:0] layer_en;
    logic [TW-1:0] tmo_limit;
    logic          start;
    logic          abort;
    logic [IW-1:0] cur_layer;
    logic          busy;
    logic          seq_done;
    logic          error;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    layer_sequencer_if #(.CFG_W(CW)) core_if ();

    layer_sequencer #(
        .NUM_LAYERS (NL),
        .CFG_W      (CW),
        .GAP_CYCLES (1),
        .TMO_W      (TW)
    ) dut (
        .core_clk     (core_clk),
        .core_reset_n (core_reset_n),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_idx   (cfg_wr_idx),
        .cfg_wr_data  (cfg_wr_data),
        .layer_en     (layer_en),
        .tmo_limit    (tmo_limit),
        .start        (start),
        .abort        (abort),
        .core         (core_if),
        .cur_layer    (cur_layer),
        .busy         (busy),
        .seq_done     (seq_done),
        .error        (error)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Launch pulses seen, sampled mid-cycle.
    always @(negedge core_clk) begin
        if (core_if.layer_start === 1'b1) start_cnt++;
    end

    function automatic logic [CW-1:0] desc(input int i);
        return 64'h1100_2200_3300_4400 + 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return core_if.layer_cfg_valid;
            1:       return core_if.layer_start;
            default: return seq_done;
        endcase
    endfunction

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the selected output is high or the budget runs out.
    task automatic wait_sig(input int sel, input int budget, input string tag, output int cycles);
        cycles = 0;
        while (sig(sel) !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        check({tag, "_seen"}, 64'(sig(sel)), 64'd1);
    endtask

    initial begin
        int cyc;
        int base;
        int exp_l;
        bit stall_ok;

        core_reset_n            = 1'b1;
        cfg_wr_en               = 1'b0;
        cfg_wr_idx              = '0;
        cfg_wr_data             = '0;
        layer_en                = '0;
        tmo_limit               = '0;
        start                   = 1'b0;
        abort                   = 1'b0;
        core_if.layer_cfg_ready = 1'b0;
        core_if.layer_done      = 1'b0;

        // Reset state
        #2 core_reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(core_if.layer_cfg_valid), 0);
        check("rst_start", 64'(core_if.layer_start), 0);
        check("rst_cfg", core_if.layer_cfg, 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_seq_done", 64'(seq_done), 0);
        check("rst_error", 64'(error), 0);
        check("rst_cur_layer", 64'(cur_layer), 0);
        tick();
        tick();
        core_reset_n = 1'b1;
        tick();

        // Program all descriptor slots
        for (int i = 0; i < int'(NL); i++) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_idx  = IW'(i);
            cfg_wr_data = desc(i);
            tick();
        end
        cfg_wr_en = 1'b0;

        // Full sequence: all layers, done 20 cycles after each launch
        core_if.layer_cfg_ready = 1'b1;
        layer_en = 8'hFF;
        base = start_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 1);
        for (int l = 0; l < int'(NL); l++) begin
            wait_sig(0, 10, "full_valid", cyc);
            if (l == 0) check("first_valid_latency", 64'(cyc), 1);
            else        check("gap_latency", 64'(cyc), 2);
            check("full_cur_layer", 64'(cur_layer), 64'(l));
            check("full_cfg", core_if.layer_cfg, desc(l));
            tick();
            check("full_launch", 64'(core_if.layer_start), 1);
            repeat (20) tick();
            core_if.layer_done = 1'b1;
            tick();
            core_if.layer_done = 1'b0;
        end
        wait_sig(2, 5, "full_seq_done", cyc);
        check("full_done_latency", 64'(cyc), 1);
        check("full_error", 64'(error), 0);
        check("full_busy_finish", 64'(busy), 1);
        check("full_start_count", 64'(start_cnt - base), 8);
        tick();
        check("full_done_pulse", 64'(seq_done), 0);
        check("full_idle_busy", 64'(busy), 0);

        // Sparse mask with backpressure
        core_if.layer_cfg_ready = 1'b0;
        layer_en = 8'b0001_0100;
        base = start_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_l = (k == 0) ? 2 : 4;
            wait_sig(0, 20, "sparse_valid", cyc);
            check("sparse_cur_layer", 64'(cur_layer), 64'(exp_l));
            check("sparse_cfg", core_if.layer_cfg, desc(exp_l));
            stall_ok = 1'b1;
            repeat (5) begin
                tick();
                if (!(core_if.layer_cfg_valid === 1'b1 && core_if.layer_cfg === desc(exp_l)
                      && core_if.layer_start === 1'b0)) stall_ok = 1'b0;
            end
            check("sparse_stall_stable", 64'(stall_ok), 1);
            core_if.layer_cfg_ready = 1'b1;
            tick();
            core_if.layer_cfg_ready = 1'b0;
            check("sparse_launch", 64'(core_if.layer_start), 1);
            repeat (5) tick();
            core_if.layer_done = 1'b1;
            tick();
            core_if.layer_done = 1'b0;
        end
        wait_sig(2, 20, "sparse_seq_done", cyc);
        check("sparse_start_count", 64'(start_cnt - base), 2);
        check("sparse_error", 64'(error), 0);
        tick();

        // Empty mask: eight SCAN cycles then FINISH
        layer_en = '0;
        base = start_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(2, 12, "empty_seq_done", cyc);
        check("empty_latency", 64'(cyc), 8);
        check("empty_no_start", 64'(start_cnt - base), 0);
        tick();

        // Watchdog: limit 100, core never completes
        core_if.layer_cfg_ready = 1'b1;
        layer_en  = 8'h01;
        tmo_limit = 24'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(0, 10, "wdog_valid", cyc);
        tick();
        check("wdog_launch", 64'(core_if.layer_start), 1);
        wait_sig(2, 150, "wdog_seq_done", cyc);
        check("wdog_latency", 64'(cyc), 101);
        check("wdog_error", 64'(error), 1);
        tick();
        check("error_sticky", 64'(error), 1);
        check("wdog_idle", 64'(busy), 0);
        tmo_limit = '0;

        // Abort during RUN of layer 3
        layer_en = 8'hFF;
        base = start_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_error", 64'(error), 0);
        for (int l = 0; l < 3; l++) begin
            wait_sig(0, 10, "abort_valid", cyc);
            tick();
            repeat (3) tick();
            core_if.layer_done = 1'b1;
            tick();
            core_if.layer_done = 1'b0;
        end
        wait_sig(0, 10, "abort_valid3", cyc);
        tick();
        repeat (3) tick();
        check("abort_cur_layer", 64'(cur_layer), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_seq_done", 64'(seq_done), 1);
        check("abort_error", 64'(error), 1);
        check("abort_valid_low", 64'(core_if.layer_cfg_valid), 0);
        repeat (30) tick();
        check("abort_no_layer4", 64'(start_cnt - base), 4);
        check("abort_idle", 64'(busy), 0);

        // Restart, ignored start while busy, reset mid-LOAD
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_clears_error", 64'(error), 0);
        wait_sig(0, 10, "restart_valid", cyc);
        check("restart_layer0", 64'(cur_layer), 0);
        check("restart_cfg0", core_if.layer_cfg, desc(0));
        tick();
        core_if.layer_cfg_ready = 1'b0;
        check("restart_launch", 64'(core_if.layer_start), 1);
        repeat (3) tick();
        core_if.layer_done = 1'b1;
        tick();
        core_if.layer_done = 1'b0;
        wait_sig(0, 10, "restart_valid1", cyc);
        check("restart_layer1", 64'(cur_layer), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignored_start_idx", 64'(cur_layer), 1);
        check("ignored_start_valid", 64'(core_if.layer_cfg_valid), 1);
        #2 core_reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(core_if.layer_cfg_valid), 0);
        check("async_rst_busy", 64'(busy), 0);
        check("async_rst_cur_layer", 64'(cur_layer), 0);
        check("async_rst_cfg", core_if.layer_cfg, 0);
        tick();
        check("async_rst_no_seq_done", 64'(seq_done), 0);
        core_reset_n = 1'b1;
        tick();
        check("post_rst_busy", 64'(busy), 0);

        // Slots cleared by reset
        layer_en = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(0, 10, "post_rst_valid", cyc);
        check("post_rst_slot_cleared", core_if.layer_cfg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_layer_sequencer
